// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the mini-cpu datapath
//
// Purpose: sequences each instruction through FETCH, DECODE, EXEC, MEM and WB
// against a single shared instruction/data memory with a ready handshake.
// Illegal encodings park the FSM in TRAP (sticky until i_rst).
//
// Optional feature macro: MULTICYCLE_CTRL_INSTRET_EN adds o_instret, a 64-bit
// retired-instruction counter.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_instr        instruction register contents (stable from DECODE to next FETCH)
//   i_mem_ready    memory completes the current request this cycle
//   i_alu_zero     ALU result == 0
//   o_mem_req      memory request valid
//   o_mem_write    request is a store
//   o_mem_size     access size (instr[13:12]) during MEM
//   o_i_or_d       address select: 0 = PC, 1 = ALU-out register
//   o_ir_write     load instruction register
//   o_pc_write     update PC
//   o_pc_src       0 = ALU result, 1 = ALU-out register
//   o_reg_write    register file write enable
//   o_mem_to_reg   write-back select: 0 = ALU-out, 1 = memory data
//   o_alu_src_a    00 = PC, 01 = rs1, 10 = old PC
//   o_alu_src_b    00 = rs2, 01 = constant 4, 10 = immediate
//   o_alu_ctrl     ALU operation
//   o_illegal      sticky trap flag
//   o_instret      retired-instruction count (only with MULTICYCLE_CTRL_INSTRET_EN)

module multicycle_control #(
  parameter int XLEN = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instr,
  input  logic        i_mem_ready,
  input  logic        i_alu_zero,
  output logic        o_mem_req,
  output logic        o_mem_write,
  output logic [1:0]  o_mem_size,
  output logic        o_i_or_d,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_pc_src,
  output logic        o_reg_write,
  output logic        o_mem_to_reg,
  output logic [1:0]  o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_illegal
`ifdef MULTICYCLE_CTRL_INSTRET_EN
  ,
  output logic [63:0] o_instret
`endif
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_is_r;
  logic       w_is_imm;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_br;
  logic       w_f3_alu_ok;
  logic       w_ls_ok;
  logic       w_legal;
  logic       w_is_sub;
  logic [3:0] w_alu_op;
  logic       w_unused;

  assign w_opcode   = i_instr[6:0];
  assign w_f3       = i_instr[14:12];
  assign w_f7       = i_instr[31:25];
  assign w_is_r     = (w_opcode == 7'd51);
  assign w_is_imm   = (w_opcode == 7'd19);
  assign w_is_load  = (w_opcode == 7'd3);
  assign w_is_store = (w_opcode == 7'd35);
  assign w_is_br    = (w_opcode == 7'd99);

  // Register fields and immediates are consumed by the datapath, not here.
  assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

  // funct3 values shared by R-type (funct7=0) and OP-IMM: add/slt/xor/or/and.
  // Shifts (f3=1,5) and sltu (f3=3) fall outside the legal set and trap.
  assign w_f3_alu_ok = (w_f3 == 3'd0) || (w_f3 == 3'd2) || (w_f3 == 3'd4) ||
                       (w_f3 == 3'd6) || (w_f3 == 3'd7);

  // Word access always; doubleword only on a 64-bit datapath.
  assign w_ls_ok = (w_f3 == 3'b010) || ((XLEN == 64) && (w_f3 == 3'b011));

  assign w_legal = (w_is_r && (w_f7 == 7'd0) && w_f3_alu_ok) ||
                   (w_is_r && (w_f7 == 7'd32) && (w_f3 == 3'd0)) ||
                   (w_is_imm && w_f3_alu_ok) ||
                   ((w_is_load || w_is_store) && w_ls_ok) ||
                   (w_is_br && ((w_f3 == 3'd0) || (w_f3 == 3'd1)));

  // Only R-type honours funct7 for SUB; addi with imm[10]=1 stays an ADD.
  assign w_is_sub = w_is_r && (w_f7 == 7'd32);

  always_comb begin
    w_alu_op = ALU_ADD;
    case (w_f3)
      3'd0:    w_alu_op = w_is_sub ? ALU_SUB : ALU_ADD;
      3'd2:    w_alu_op = ALU_SLT;
      3'd4:    w_alu_op = ALU_XOR;
      3'd6:    w_alu_op = ALU_OR;
      3'd7:    w_alu_op = ALU_AND;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_mem_req    = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_size   = 2'b00;
    o_i_or_d     = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_ctrl   = ALU_AND;
    o_illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        o_mem_req   = 1'b1;
        o_alu_src_b = 2'b01;
        o_alu_ctrl  = ALU_ADD;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively form the branch target from the old PC.
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b10;
        o_alu_ctrl  = ALU_ADD;
        w_next      = w_legal ? S_EXEC : S_TRAP;
      end

      S_EXEC: begin
        o_alu_src_a = 2'b01;
        if (w_is_r) begin
          o_alu_src_b = 2'b00;
          o_alu_ctrl  = w_alu_op;
          w_next      = S_WB;
        end else if (w_is_imm) begin
          o_alu_src_b = 2'b10;
          o_alu_ctrl  = w_alu_op;
          w_next      = S_WB;
        end else if (w_is_load || w_is_store) begin
          o_alu_src_b = 2'b10;
          o_alu_ctrl  = ALU_ADD;
          w_next      = S_MEM;
        end else if (w_is_br) begin
          o_alu_src_b = 2'b00;
          o_alu_ctrl  = ALU_SUB;
          o_pc_src    = 1'b1;
          // f3[0] distinguishes bne from beq.
          o_pc_write  = w_f3[0] ? ~i_alu_zero : i_alu_zero;
          w_next      = S_FETCH;
        end else begin
          w_next = S_TRAP;
        end
      end

      S_MEM: begin
        o_mem_req   = 1'b1;
        o_i_or_d    = 1'b1;
        o_mem_write = w_is_store;
        o_mem_size  = i_instr[13:12];
        if (i_mem_ready) begin
          w_next = w_is_store ? S_FETCH : S_WB;
        end
      end

      S_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = w_is_load;
        w_next       = S_FETCH;
      end

      S_TRAP: begin
        o_illegal = 1'b1;
      end

      default: begin
        w_next = S_FETCH;
      end
    endcase

    // Reset abandons any request in the same cycle, not at the next edge.
    if (i_rst) begin
      w_next       = S_FETCH;
      o_mem_req    = 1'b0;
      o_mem_write  = 1'b0;
      o_mem_size   = 2'b00;
      o_i_or_d     = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_pc_src     = 1'b0;
      o_reg_write  = 1'b0;
      o_mem_to_reg = 1'b0;
      o_alu_src_a  = 2'b00;
      o_alu_src_b  = 2'b00;
      o_alu_ctrl   = ALU_AND;
      o_illegal    = 1'b0;
    end
  end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  logic        w_retire;
  logic [63:0] r_instret;

  // Only WB, store-MEM and branch-EXEC ever step into FETCH, so this is
  // exactly one pulse per retired instruction and never fires from TRAP.
  assign w_retire = ~i_rst && (w_next == S_FETCH) &&
                    ((r_state == S_WB) || (r_state == S_MEM) || (r_state == S_EXEC));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instret <= 64'd0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign o_instret = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven bench for multicycle_control (XLEN=32 and XLEN=64 instances)

module tb_multicycle_control;

  // Output vector layout:
  // [18] mem_req [17] mem_write [16:15] mem_size [14] i_or_d [13] ir_write
  // [12] pc_write [11] pc_src [10] reg_write [9] mem_to_reg [8:7] src_a
  // [6:5] src_b [4:1] alu_ctrl [0] illegal
  localparam logic [18:0] ZERO    = 19'b0_0_00_0_0_0_0_0_0_00_00_0000_0;
  localparam logic [18:0] F_RDY   = 19'b1_0_00_0_1_1_0_0_0_00_01_0010_0;
  localparam logic [18:0] F_WAIT  = 19'b1_0_00_0_0_0_0_0_0_00_01_0010_0;
  localparam logic [18:0] DEC     = 19'b0_0_00_0_0_0_0_0_0_10_10_0010_0;
  localparam logic [18:0] EX_ADD  = 19'b0_0_00_0_0_0_0_0_0_01_00_0010_0;
  localparam logic [18:0] EX_SUB  = 19'b0_0_00_0_0_0_0_0_0_01_00_0110_0;
  localparam logic [18:0] EX_XOR  = 19'b0_0_00_0_0_0_0_0_0_01_00_0011_0;
  localparam logic [18:0] EX_SLTI = 19'b0_0_00_0_0_0_0_0_0_01_10_0111_0;
  localparam logic [18:0] EX_ORI  = 19'b0_0_00_0_0_0_0_0_0_01_10_0001_0;
  localparam logic [18:0] EX_ANDI = 19'b0_0_00_0_0_0_0_0_0_01_10_0000_0;
  localparam logic [18:0] EX_LS   = 19'b0_0_00_0_0_0_0_0_0_01_10_0010_0;
  localparam logic [18:0] EX_BR_T = 19'b0_0_00_0_0_1_1_0_0_01_00_0110_0;
  localparam logic [18:0] EX_BR_N = 19'b0_0_00_0_0_0_1_0_0_01_00_0110_0;
  localparam logic [18:0] WB_ALU  = 19'b0_0_00_0_0_0_0_1_0_00_00_0000_0;
  localparam logic [18:0] WB_LD   = 19'b0_0_00_0_0_0_0_1_1_00_00_0000_0;
  localparam logic [18:0] MEM_LW  = 19'b1_0_10_1_0_0_0_0_0_00_00_0000_0;
  localparam logic [18:0] MEM_SW  = 19'b1_1_10_1_0_0_0_0_0_00_00_0000_0;
  localparam logic [18:0] MEM_LD  = 19'b1_0_11_1_0_0_0_0_0_00_00_0000_0;
  localparam logic [18:0] TRAP    = 19'b0_0_00_0_0_0_0_0_0_00_00_0000_1;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_SLTI = 32'h0050A193;
  localparam logic [31:0] I_ORI  = 32'h0050E193;
  localparam logic [31:0] I_ANDI = 32'h0050F193;
  localparam logic [31:0] I_SLLI = 32'h00109193;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_LD   = 32'h0000B183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        rdy;
    logic        z;
    logic [18:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  wire  [18:0] v32;
  wire  [18:0] v64;
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
  wire [63:0] ir32;
  wire [63:0] ir64;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.XLEN(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_mem_ready(mem_ready), .i_alu_zero(alu_zero),
    .o_mem_req(v32[18]), .o_mem_write(v32[17]), .o_mem_size(v32[16:15]), .o_i_or_d(v32[14]),
    .o_ir_write(v32[13]), .o_pc_write(v32[12]), .o_pc_src(v32[11]), .o_reg_write(v32[10]),
    .o_mem_to_reg(v32[9]), .o_alu_src_a(v32[8:7]), .o_alu_src_b(v32[6:5]),
    .o_alu_ctrl(v32[4:1]), .o_illegal(v32[0])
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    , .o_instret(ir32)
`endif
  );

  multicycle_control #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_mem_ready(mem_ready), .i_alu_zero(alu_zero),
    .o_mem_req(v64[18]), .o_mem_write(v64[17]), .o_mem_size(v64[16:15]), .o_i_or_d(v64[14]),
    .o_ir_write(v64[13]), .o_pc_write(v64[12]), .o_pc_src(v64[11]), .o_reg_write(v64[10]),
    .o_mem_to_reg(v64[9]), .o_alu_src_a(v64[8:7]), .o_alu_src_b(v64[6:5]),
    .o_alu_ctrl(v64[4:1]), .o_illegal(v64[0])
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    , .o_instret(ir64)
`endif
  );

  task automatic add(input logic r, input logic [31:0] ins, input logic rdy, input logic z,
                     input logic [18:0] e);
    vec_t v;
    v.rst = r; v.ins = ins; v.rdy = rdy; v.z = z; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic alu_seq(input logic [31:0] ins, input logic [18:0] ex);
    add(1'b0, ins, 1'b1, 1'b0, F_RDY);
    add(1'b0, ins, 1'b1, 1'b0, DEC);
    add(1'b0, ins, 1'b1, 1'b0, ex);
    add(1'b0, ins, 1'b1, 1'b0, WB_ALU);
  endtask

  task automatic br_seq(input logic [31:0] ins, input logic z, input logic [18:0] ex);
    add(1'b0, ins, 1'b1, z, F_RDY);
    add(1'b0, ins, 1'b1, z, DEC);
    add(1'b0, ins, 1'b1, z, ex);
  endtask

  // Drive on the falling edge, sample 2 time units later (well before the rising edge).
  task automatic cyc(input logic r, input logic [31:0] ins, input logic rdy, input logic z);
    @(negedge clk);
    rst = r; instr = ins; mem_ready = rdy; alu_zero = z;
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (check %0d): got %h expected %h", name, checks, got, exp);
    end
  endtask

  task automatic step(input string name, input logic r, input logic [31:0] ins, input logic rdy,
                      input logic z, input logic [18:0] e);
    cyc(r, ins, rdy, z);
    chk(name, {45'd0, v32}, {45'd0, e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr = 32'd0; mem_ready = 1'b0; alu_zero = 1'b0;

    // Reset, then add with zero-wait memory: back at FETCH on cycle 5.
    repeat (3) add(1'b1, I_ADD, 1'b1, 1'b0, ZERO);
    alu_seq(I_ADD, EX_ADD);
    alu_seq(I_SUB, EX_SUB);
    alu_seq(I_XOR, EX_XOR);
    alu_seq(I_SLTI, EX_SLTI);
    alu_seq(I_ORI, EX_ORI);
    alu_seq(I_ANDI, EX_ANDI);
    // lw with fetch waits and three MEM wait cycles; ready ignored in DECODE/EXEC/WB.
    add(1'b0, I_LW, 1'b0, 1'b0, F_WAIT);
    add(1'b0, I_LW, 1'b0, 1'b0, F_WAIT);
    add(1'b0, I_LW, 1'b1, 1'b0, F_RDY);
    add(1'b0, I_LW, 1'b0, 1'b0, DEC);
    add(1'b0, I_LW, 1'b0, 1'b0, EX_LS);
    repeat (3) add(1'b0, I_LW, 1'b0, 1'b0, MEM_LW);
    add(1'b0, I_LW, 1'b1, 1'b0, MEM_LW);
    add(1'b0, I_LW, 1'b0, 1'b0, WB_LD);
    // sw: four cycles, store goes straight back to FETCH.
    add(1'b0, I_SW, 1'b1, 1'b0, F_RDY);
    add(1'b0, I_SW, 1'b1, 1'b0, DEC);
    add(1'b0, I_SW, 1'b1, 1'b0, EX_LS);
    add(1'b0, I_SW, 1'b1, 1'b0, MEM_SW);
    // Branches, both alu_zero polarities.
    br_seq(I_BEQ, 1'b1, EX_BR_T);
    br_seq(I_BNE, 1'b1, EX_BR_N);
    br_seq(I_BNE, 1'b0, EX_BR_T);
    br_seq(I_BEQ, 1'b0, EX_BR_N);
    // rst during a fetch wait drops mem_req the same cycle; fetch restarts.
    add(1'b0, I_ADD, 1'b0, 1'b0, F_WAIT);
    add(1'b1, I_ADD, 1'b0, 1'b0, ZERO);
    add(1'b0, I_ADD, 1'b0, 1'b0, F_WAIT);
    add(1'b0, I_ADD, 1'b1, 1'b0, F_RDY);
    add(1'b0, I_ADD, 1'b1, 1'b0, DEC);
    add(1'b1, I_ADD, 1'b1, 1'b0, ZERO);
    // rst during a MEM wait.
    add(1'b0, I_LW, 1'b1, 1'b0, F_RDY);
    add(1'b0, I_LW, 1'b1, 1'b0, DEC);
    add(1'b0, I_LW, 1'b1, 1'b0, EX_LS);
    add(1'b0, I_LW, 1'b0, 1'b0, MEM_LW);
    add(1'b1, I_LW, 1'b0, 1'b0, ZERO);
    // ld is illegal at XLEN=32: sticky TRAP for 10 cycles regardless of inputs.
    add(1'b0, I_LD, 1'b1, 1'b0, F_RDY);
    add(1'b0, I_LD, 1'b1, 1'b0, DEC);
    for (int k = 0; k < 10; k++) add(1'b0, I_LD, k[0], ~k[0], TRAP);
    add(1'b1, I_LD, 1'b1, 1'b0, ZERO);
    add(1'b0, I_ADD, 1'b1, 1'b0, F_RDY);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].ins, tbl[i].rdy, tbl[i].z);
      chk($sformatf("table row %0d", i), {45'd0, v32}, {45'd0, tbl[i].exp});
    end

    // ld on both widths: 64-bit completes as a doubleword load, 32-bit traps.
    cyc(1'b1, I_LD, 1'b1, 1'b0);
    chk("ld64 reset", {45'd0, v64}, {45'd0, ZERO});
    cyc(1'b0, I_LD, 1'b1, 1'b0);
    chk("ld64 fetch", {45'd0, v64}, {45'd0, F_RDY});
    cyc(1'b0, I_LD, 1'b1, 1'b0);
    chk("ld64 decode", {45'd0, v64}, {45'd0, DEC});
    cyc(1'b0, I_LD, 1'b1, 1'b0);
    chk("ld64 exec", {45'd0, v64}, {45'd0, EX_LS});
    chk("ld32 trap", {45'd0, v32}, {45'd0, TRAP});
    cyc(1'b0, I_LD, 1'b0, 1'b0);
    chk("ld64 mem wait", {45'd0, v64}, {45'd0, MEM_LD});
    cyc(1'b0, I_LD, 1'b1, 1'b0);
    chk("ld64 mem done", {45'd0, v64}, {45'd0, MEM_LD});
    cyc(1'b0, I_LD, 1'b1, 1'b0);
    chk("ld64 wb", {45'd0, v64}, {45'd0, WB_LD});
    chk("ld32 trap held", {45'd0, v32}, {45'd0, TRAP});
    cyc(1'b0, I_ADD, 1'b1, 1'b0);
    chk("ld64 refetch", {45'd0, v64}, {45'd0, F_RDY});

    // Unimplemented shift-immediate traps.
    step("slli reset", 1'b1, I_SLLI, 1'b1, 1'b0, ZERO);
    step("slli fetch", 1'b0, I_SLLI, 1'b1, 1'b0, F_RDY);
    step("slli decode", 1'b0, I_SLLI, 1'b1, 1'b0, DEC);
    step("slli trap", 1'b0, I_SLLI, 1'b1, 1'b0, TRAP);

    // add, sw, beq, then an illegal word: three retirements, none in TRAP.
    step("seq reset", 1'b1, I_ADD, 1'b1, 1'b0, ZERO);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    chk("instret reset", ir32, 64'd0);
`endif
    step("seq add f", 1'b0, I_ADD, 1'b1, 1'b0, F_RDY);
    step("seq add d", 1'b0, I_ADD, 1'b1, 1'b0, DEC);
    step("seq add e", 1'b0, I_ADD, 1'b1, 1'b0, EX_ADD);
    step("seq add w", 1'b0, I_ADD, 1'b1, 1'b0, WB_ALU);
    step("seq sw f", 1'b0, I_SW, 1'b1, 1'b0, F_RDY);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    chk("instret after add", ir32, 64'd1);
`endif
    step("seq sw d", 1'b0, I_SW, 1'b1, 1'b0, DEC);
    step("seq sw e", 1'b0, I_SW, 1'b1, 1'b0, EX_LS);
    step("seq sw m", 1'b0, I_SW, 1'b1, 1'b0, MEM_SW);
    step("seq beq f", 1'b0, I_BEQ, 1'b1, 1'b1, F_RDY);
    step("seq beq d", 1'b0, I_BEQ, 1'b1, 1'b1, DEC);
    step("seq beq e", 1'b0, I_BEQ, 1'b1, 1'b1, EX_BR_T);
    step("seq bad f", 1'b0, I_BAD, 1'b1, 1'b0, F_RDY);
    step("seq bad d", 1'b0, I_BAD, 1'b1, 1'b0, DEC);
    for (int k = 0; k < 4; k++) begin
      step("seq bad trap", 1'b0, I_BAD, 1'b1, 1'b0, TRAP);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
      chk("instret in trap", ir32, 64'd3);
      chk("instret64 in trap", ir64, 64'd3);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the next mini-cpu datapath.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, with a ready handshake to a single shared instruction/data memory.
- Extends the single-cycle decoder: XLEN-parametrised load/store widths, OP-IMM, BNE, XOR/SLT, and a sticky illegal-instruction trap.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. At 64, the ld/sd encodings (funct3=011) are additionally legal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr  in  32  instruction register contents; stable from DECODE until the next FETCH
- mem_ready  in  1  memory completes the current request this cycle
- alu_zero  in  1  ALU result == 0
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store (qualified by mem_req)
- mem_size  out  2  access size = instr[13:12]
- i_or_d  out  1  address select: 0 = PC, 1 = ALU-out register
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  1  0 = ALU result (PC+4), 1 = ALU-out register (branch target)
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back select: 0 = ALU-out, 1 = memory data
- alu_src_a  out  2  00 = PC, 01 = rs1, 10 = old PC
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0011 XOR
- illegal  out  1  sticky trap flag

Behaviour:
- State register updates on the rising clk edge only.
- All outputs are decoded combinationally from the current state and instr.
- Every output not listed for a state is 0.
- Reset
  - While rst=1: state forced to FETCH; all outputs forced to 0, including illegal.
  - The first mem_req is asserted in the first cycle with rst=0.
  - rst mid-operation, including during a memory wait: the request is abandoned and mem_req drops in that same cycle.
- FETCH
  - mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_ctrl=ADD.
  - ir_write and pc_write are asserted only in the cycle where mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE (always 1 cycle)
  - alu_src_a=10, alu_src_b=10, alu_ctrl=ADD: branch target into ALU-out.
  - Next state is EXEC if the opcode/funct are legal, otherwise TRAP.
- Legal set
  - opcode 51 (R-type), funct7=0: add (f3=0), slt (2), xor (4), or (6), and (7).
  - opcode 51, funct7=32: sub (f3=0) only.
  - opcode 19 (OP-IMM): addi, slti, xori, ori, andi.
  - opcode 3 (load): f3=010; f3=011 also legal if XLEN=64.
  - opcode 35 (store): same funct3 rule as load.
  - opcode 99 (branch): beq (f3=0), bne (f3=1).
  - Everything else is illegal.
- EXEC (1 cycle)
  - R-type: alu_src_a=01, alu_src_b=00, alu_ctrl per funct → WB.
  - OP-IMM: alu_src_a=01, alu_src_b=10, alu_ctrl per funct3 → WB.
  - Load/store: alu_src_a=01, alu_src_b=10, ADD → MEM.
  - Branch: alu_src_a=01, alu_src_b=00, SUB, pc_src=1; pc_write = alu_zero for beq, !alu_zero for bne → FETCH.
- MEM
  - mem_req=1, i_or_d=1, mem_write=1 for stores; mem_size valid.
  - Holds while mem_ready=0.
  - On mem_ready=1: load → WB, store → FETCH.
- WB (1 cycle)
  - reg_write=1; mem_to_reg=1 for loads, 0 otherwise → FETCH.
- TRAP
  - illegal=1, all other outputs 0.
  - Remains in TRAP until rst.
- Latency with zero-wait memory (mem_ready tied high):
  - R/OP-IMM: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
- MULTICYCLE_CTRL_INSTRET_EN defined:
  - Adds output port instret (64 bits).
  - Reset to 0 by rst.
  - Increments by 1 on each transition into FETCH from WB, MEM (store) or EXEC (branch), i.e. once per retired instruction.
  - Wraps from 2^64-1 to 0.
  - Never increments in TRAP.
- MULTICYCLE_CTRL_INSTRET_EN not defined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- rst=1 for 3 cycles, then 0, mem_ready=1, instr=0x002081B3 (add x3,x1,x2) → all outputs 0 during reset; then FETCH, DECODE, EXEC (alu_ctrl=0010, src_b=00), WB (reg_write=1); back at FETCH on cycle 5.
- lw 0x0000A183 with mem_ready held low for 3 MEM cycles → mem_req=1, i_or_d=1, mem_size=10 held for 4 cycles; then WB with mem_to_reg=1.
- beq 0x00208463 with alu_zero=1, then bne 0x00209463 with alu_zero=1 → pc_write=1, pc_src=1 for beq; pc_write=0 for bne; both return to FETCH after EXEC.
- XLEN=32: instr 0x0000B183 (ld) → DECODE goes to TRAP, illegal=1 held for 10 cycles; rst clears it. XLEN=64: the same instr completes as a load with mem_size=11.
- rst asserted during a FETCH wait (mem_ready=0) → mem_req=0 in that cycle; the fetch restarts after rst deasserts.
- MULTICYCLE_CTRL_INSTRET_EN defined: sequence add, sw, beq, then illegal 0xFFFFFFFF → instret=3 and stays 3 in TRAP.
